signed_divider: RTL and testbench
=================================

# signed_divider

Multi-cycle WIDTH-bit signed integer divider for the datapath's ALU stage, issued with a start/done handshake. The block converts two's-complement operands to magnitudes, runs a restoring shift-subtract division, then re-applies signs to the results. It handles the decode side of two's-complement arithmetic, where the operand path only produces negated values.

## Interface
- WIDTH, 8, operand and result width in bits
- CLK  input  1  clock; all state updates on the rising edge
- RESET  input  1  asynchronous, active-low reset
- START  input  1  request a division; sampled only in IDLE
- DIVIDEND  input  WIDTH  signed two's-complement dividend; sampled with START
- DIVISOR  input  WIDTH  signed two's-complement divisor; sampled with START
- QUOTIENT  output  WIDTH  signed quotient, registered
- REMAINDER  output  WIDTH  signed remainder, registered
- BUSY  output  1  high in every state except IDLE
- DONE  output  1  one-cycle pulse; results are valid from this cycle
- DIV_ZERO  output  1  registered flag; set if the last operation had DIVISOR == 0

## Operation
- States: IDLE, ABS, DIVIDE, FIX, FINISH.
- IDLE, START=1: latch the operands, record sign_q = DIVIDEND[MSB] ^ DIVISOR[MSB] and sign_r = DIVIDEND[MSB]. Go to ABS.
- ABS:
  - Replace each operand with its magnitude: ~x+1 if negative, otherwise unchanged. Magnitudes are WIDTH-bit unsigned, so -2^(WIDTH-1) maps to 2^(WIDTH-1).
  - If the divisor is zero, go to FINISH with QUOTIENT = all ones, REMAINDER = original DIVIDEND, DIV_ZERO = 1.
  - Otherwise clear the partial remainder and the iteration counter, then go to DIVIDE.
- DIVIDE, one iteration per cycle, WIDTH iterations:
  - Shift {remainder, dividend} left by 1.
  - Trial-subtract the divisor using a WIDTH+1-bit difference.
  - If the difference is non-negative, keep it and set quotient bit 1; otherwise restore and set 0.
  - Counter wraps at WIDTH-1, then go to FIX.
- FIX:
  - QUOTIENT = sign_q ? ~q+1 : q and REMAINDER = sign_r ? ~r+1 : r. This gives truncation toward zero; the remainder takes the dividend's sign.
  - DIV_ZERO = 0. Go to FINISH.
- FINISH: DONE=1 for this cycle only, then return to IDLE.
- Overflow: -2^(WIDTH-1) / -1 wraps to QUOTIENT = 2^(WIDTH-1) (8'h80) with REMAINDER = 0. No flag is raised.
- START while BUSY is ignored. No queueing; operands already latched are unaffected.
- QUOTIENT, REMAINDER and DIV_ZERO hold their values until the next FINISH.

## Timing
- Reset (RESET=0, asynchronous): state = IDLE, QUOTIENT = 0, REMAINDER = 0, BUSY = 0, DONE = 0, DIV_ZERO = 0, all internal registers 0.
- Reset mid-operation aborts immediately. No DONE is produced, and outputs read 0 after release.
- Let edge N be the edge that samples START=1 in IDLE:
  - BUSY rises after edge N.
  - Normal case: DONE is high between edges N+WIDTH+2 and N+WIDTH+3, i.e. 10 edges for WIDTH=8.
  - Divide by zero: DONE is high between edges N+2 and N+3.
- BUSY falls on the same edge DONE falls.
- Back-to-back operation: START sampled at edge N+WIDTH+3 (IDLE re-entered) is accepted. START held high throughout produces one operation every WIDTH+3 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package div_pkg: state enum (IDLE, ABS, DIVIDE, FIX, FINISH), DEFAULT_WIDTH = 8, and the counter width localparam $clog2(WIDTH).
- Sub-module cond_negate (parameter WIDTH; inputs X and NEG; output Y = NEG ? ~X+1 : X), purely combinational. Instantiated for operand magnitude in ABS and result sign fix in FIX; sharing one instance per operand via a mux is acceptable.
- The top level contains the FSM, counter, and shift/subtract datapath.

## Test plan
- DIVIDEND=100, DIVISOR=7, START at edge N -> DONE exactly at edge N+10; QUOTIENT=8'h0E, REMAINDER=8'h02, DIV_ZERO=0.
- DIVIDEND=-100 (8'h9C), DIVISOR=7 -> QUOTIENT=8'hF2 (-14), REMAINDER=8'hFE (-2). Then DIVIDEND=100, DIVISOR=-7 -> QUOTIENT=8'hF2, REMAINDER=8'h02.
- DIVIDEND=8'h80, DIVISOR=8'hFF -> QUOTIENT=8'h80, REMAINDER=8'h00. DIVIDEND=8'h80, DIVISOR=8'h80 -> QUOTIENT=8'h01, REMAINDER=8'h00.
- DIVIDEND=55, DIVISOR=0 -> DONE at edge N+2; DIV_ZERO=1, QUOTIENT=8'hFF, REMAINDER=8'h37. The next valid divide clears DIV_ZERO.
- START pulsed again at edge N+4 during a busy operation -> ignored, with a single DONE at N+10. Then assert RESET at N+5 on a fresh operation -> BUSY=0 and outputs 0 immediately, no DONE ever observed.
- Random signed operands (nonzero divisor), 1000 runs with back-to-back START -> match truncating reference division, and exactly one DONE per accepted START.

Source files
------------

// File: rtl/signed_divider_pkg.sv
// Shared types and sizing helpers for the multi-cycle signed divider.
// The divider top and its sub-module import this package.
package div_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ABS,
    DIVIDE,
    FIX,
    FINISH
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

  // Iteration counter width; a single-bit divider still needs a 1-bit counter.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/signed_divider_cond_negate.sv
// Conditional two's-complement negation: y = neg ? -x : x.
// Used both to take operand magnitudes and to re-apply result signs.
module cond_negate #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] y_o
);

  assign y_o = neg_i ? (~x_i + WIDTH'(1)) : x_i;

endmodule

// File: rtl/signed_divider.sv
// Multi-cycle signed restoring divider with start/done handshake.
// Operands become magnitudes, divide unsigned, then results take their signs back.
module signed_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_zero_o
);

  localparam int CntW = cnt_width(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_e            state_q;
  logic [WIDTH-1:0]  dvd_q;       // dividend, then magnitude, then quotient bits
  logic [WIDTH-1:0]  dvs_q;
  logic [WIDTH-1:0]  rem_q;
  logic [CntW-1:0]   cnt_q;
  logic              sign_quo_q;
  logic              sign_rem_q;
  logic              zero_q;
  logic [WIDTH-1:0]  quotient_q;
  logic [WIDTH-1:0]  remainder_q;
  logic              busy_q;
  logic              done_q;
  logic              div_zero_q;

  logic              in_fix;
  logic [WIDTH-1:0]  neg_a;
  logic [WIDTH-1:0]  neg_b;
  logic [WIDTH:0]    shifted_rem;
  logic [WIDTH:0]    trial_diff;

  assign in_fix      = (state_q == FIX);
  assign shifted_rem = {rem_q, dvd_q[WIDTH-1]};
  assign trial_diff  = shifted_rem - {1'b0, dvs_q};

  // One negator per operand, shared between magnitude (ABS) and sign fix (FIX).
  cond_negate #(.WIDTH(WIDTH)) u_neg_a (
    .x_i   (dvd_q),
    .neg_i (in_fix ? sign_quo_q : dvd_q[WIDTH-1]),
    .y_o   (neg_a)
  );

  cond_negate #(.WIDTH(WIDTH)) u_neg_b (
    .x_i   (in_fix ? rem_q : dvs_q),
    .neg_i (in_fix ? sign_rem_q : dvs_q[WIDTH-1]),
    .y_o   (neg_b)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      sign_quo_q  <= 1'b0;
      sign_rem_q  <= 1'b0;
      zero_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      div_zero_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        // FINISH hands straight back to IDLE, so a START seen there is the
        // first START of the re-entered IDLE and keeps back-to-back at WIDTH+3.
        IDLE, FINISH: begin
          if (start_i) begin
            dvd_q      <= dividend_i;
            dvs_q      <= divisor_i;
            sign_quo_q <= dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1];
            sign_rem_q <= dividend_i[WIDTH-1];
            busy_q     <= 1'b1;
            state_q    <= ABS;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        ABS: begin
          if (dvs_q == '0) begin
            // Keep the original dividend; FIX commits the zero-divisor results.
            zero_q  <= 1'b1;
            state_q <= FIX;
          end else begin
            dvd_q   <= neg_a;
            dvs_q   <= neg_b;
            rem_q   <= '0;
            cnt_q   <= '0;
            zero_q  <= 1'b0;
            state_q <= DIVIDE;
          end
        end
        DIVIDE: begin
          if (!trial_diff[WIDTH]) begin
            rem_q <= trial_diff[WIDTH-1:0];
            dvd_q <= {dvd_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_q <= shifted_rem[WIDTH-1:0];
            dvd_q <= {dvd_q[WIDTH-2:0], 1'b0};
          end
          if (cnt_q == CntLast) begin
            cnt_q   <= '0;
            state_q <= FIX;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        FIX: begin
          if (zero_q) begin
            quotient_q  <= '1;
            remainder_q <= dvd_q;
            div_zero_q  <= 1'b1;
          end else begin
            quotient_q  <= neg_a;
            remainder_q <= neg_b;
            div_zero_q  <= 1'b0;
          end
          done_q  <= 1'b1;
          state_q <= FINISH;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign quotient_o  = quotient_q;
  assign remainder_o = remainder_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign div_zero_o  = div_zero_q;

endmodule

// File: tb/tb_signed_divider.sv
// Directed and back-to-back checks of signed_divider latency, results and flags.
// Each scenario task drives its own stimulus and compares inline.
module tb_signed_divider;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       busy;
  logic       done;
  logic       div_zero;

  int errors = 0;
  int checks = 0;

  signed_divider #(.WIDTH(8)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .dividend_i  (dividend),
    .divisor_i   (divisor),
    .quotient_o  (quotient),
    .remainder_o (remainder),
    .busy_o      (busy),
    .done_o      (done),
    .div_zero_o  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one division; lat is the number of edges after the START edge at
  // which DONE was first seen (0 if it never came). Returns just after DONE.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, output int lat);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = 8'h00;
    divisor  = 8'h00;
    #1;
    checks++;
    if ({quotient, remainder, busy, done, div_zero} !== 19'h0) begin
      errors++;
      $display("FAIL reset_async: got q=%h r=%h busy=%b done=%b dz=%b expected all 0",
               quotient, remainder, busy, done, div_zero);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({quotient, remainder, busy, done, div_zero} !== 19'h0) begin
      errors++;
      $display("FAIL reset_release: got q=%h r=%h busy=%b done=%b dz=%b expected all 0",
               quotient, remainder, busy, done, div_zero);
    end
    $display("reset: q=%h r=%h busy=%b done=%b dz=%b", quotient, remainder, busy, done, div_zero);
  endtask

  task automatic test_basic();
    int lat;
    @(negedge clk);
    dividend = 8'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy_rise: got %b expected 1", busy);
    end
    lat = 0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    checks++;
    if (lat !== 10) begin
      errors++;
      $display("FAIL basic_latency: got %0d expected 10", lat);
    end
    checks++;
    if ({quotient, remainder, div_zero} !== {8'h0E, 8'h02, 1'b0}) begin
      errors++;
      $display("FAIL basic_100_div_7: got q=%h r=%h dz=%b expected q=0e r=02 dz=0",
               quotient, remainder, div_zero);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL basic_busy_done_fall: got busy=%b done=%b expected 0 0", busy, done);
    end
    $display("basic: 100/7 lat=%0d q=%h r=%h dz=%b", lat, quotient, remainder, div_zero);
  endtask

  task automatic test_signs();
    logic [7:0] a_tab [3] = '{8'h9C, 8'd100, 8'h9C};
    logic [7:0] b_tab [3] = '{8'd7,  8'hF9,  8'hF9};
    logic [7:0] q_tab [3] = '{8'hF2, 8'hF2,  8'h0E};
    logic [7:0] r_tab [3] = '{8'hFE, 8'h02,  8'hFE};
    int lat;
    for (int i = 0; i < 3; i++) begin
      run_op(a_tab[i], b_tab[i], lat);
      checks++;
      if ({lat[7:0], quotient, remainder} !== {8'd10, q_tab[i], r_tab[i]}) begin
        errors++;
        $display("FAIL signs_%0d: got lat=%0d q=%h r=%h expected lat=10 q=%h r=%h",
                 i, lat, quotient, remainder, q_tab[i], r_tab[i]);
      end
      $display("signs: %h/%h lat=%0d q=%h r=%h", a_tab[i], b_tab[i], lat, quotient, remainder);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] b_tab [2] = '{8'hFF, 8'h80};
    logic [7:0] q_tab [2] = '{8'h80, 8'h01};
    int lat;
    for (int i = 0; i < 2; i++) begin
      run_op(8'h80, b_tab[i], lat);
      checks++;
      if ({quotient, remainder, div_zero} !== {q_tab[i], 8'h00, 1'b0}) begin
        errors++;
        $display("FAIL overflow_%0d: got q=%h r=%h dz=%b expected q=%h r=00 dz=0",
                 i, quotient, remainder, div_zero, q_tab[i]);
      end
      $display("overflow: 80/%h q=%h r=%h", b_tab[i], quotient, remainder);
    end
  endtask

  task automatic test_div_zero();
    int lat;
    run_op(8'd55, 8'd0, lat);
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL divzero_latency: got %0d expected 2", lat);
    end
    checks++;
    if ({quotient, remainder, div_zero} !== {8'hFF, 8'h37, 1'b1}) begin
      errors++;
      $display("FAIL divzero_result: got q=%h r=%h dz=%b expected q=ff r=37 dz=1",
               quotient, remainder, div_zero);
    end
    $display("divzero: 55/0 lat=%0d q=%h r=%h dz=%b", lat, quotient, remainder, div_zero);
    @(posedge clk);
    #1;
    checks++;
    if ({busy, done, div_zero} !== 3'b001) begin
      errors++;
      $display("FAIL divzero_hold: got busy=%b done=%b dz=%b expected 0 0 1", busy, done, div_zero);
    end
    run_op(8'd100, 8'd7, lat);
    checks++;
    if ({quotient, remainder, div_zero} !== {8'h0E, 8'h02, 1'b0}) begin
      errors++;
      $display("FAIL divzero_clear: got q=%h r=%h dz=%b expected q=0e r=02 dz=0",
               quotient, remainder, div_zero);
    end
    $display("divzero: follow-up 100/7 q=%h r=%h dz=%b", quotient, remainder, div_zero);
  endtask

  task automatic test_ignored_start();
    int dones = 0;
    int lat   = 0;
    @(negedge clk);
    dividend = 8'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (k == 3) begin
        dividend = 8'd9;
        divisor  = 8'd2;
        start    = 1'b1;
      end else if (k == 4) begin
        start = 1'b0;
      end
      if (done) begin
        dones++;
        lat = k;
        checks++;
        if ({quotient, remainder} !== {8'h0E, 8'h02}) begin
          errors++;
          $display("FAIL ignored_result: got q=%h r=%h expected q=0e r=02", quotient, remainder);
        end
      end
    end
    checks++;
    if (dones !== 1 || lat !== 10) begin
      errors++;
      $display("FAIL ignored_done_count: got dones=%0d lat=%0d expected 1 at 10", dones, lat);
    end
    $display("ignored_start: dones=%0d lat=%0d q=%h r=%h", dones, lat, quotient, remainder);
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    @(negedge clk);
    dividend = 8'h9C;
    divisor  = 8'd3;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({quotient, remainder, busy, done, div_zero} !== 19'h0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got q=%h r=%h busy=%b done=%b dz=%b expected all 0",
               quotient, remainder, busy, done, div_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    checks++;
    if (dones !== 0 || busy !== 1'b0 || quotient !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_abort: got dones=%0d busy=%b q=%h expected 0 0 00", dones, busy, quotient);
    end
    $display("reset_mid: dones=%0d busy=%b q=%h r=%h", dones, busy, quotient, remainder);
  endtask

  // START held high; each accepted operation must finish 10 edges after its
  // accepting edge, and the next one is accepted on the edge after DONE.
  task automatic test_back_to_back();
    localparam int RUNS = 1000;
    logic [7:0] cur_a, cur_b, nxt_a, nxt_b;
    logic [7:0] exp_q, exp_r, got_q, got_r;
    int ai, bi, qi, ri, dones, lat;
    int bad = 0;
    cur_a = 8'h80;
    cur_b = 8'hFF;
    @(negedge clk);
    dividend = cur_a;
    divisor  = cur_b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < RUNS; i++) begin
      nxt_a = 8'($urandom_range(0, 255));
      nxt_b = 8'($urandom_range(1, 255));
      if (i == RUNS - 1) start = 1'b0;
      dividend = nxt_a;
      divisor  = nxt_b;
      ai = int'($signed(cur_a));
      bi = int'($signed(cur_b));
      qi = ai / bi;
      ri = ai % bi;
      exp_q = qi[7:0];
      exp_r = ri[7:0];
      dones = 0;
      lat   = 0;
      got_q = 8'h00;
      got_r = 8'h00;
      for (int k = 1; k <= 11; k++) begin
        @(posedge clk);
        #1;
        if (done) begin
          dones++;
          lat   = k;
          got_q = quotient;
          got_r = remainder;
        end
      end
      checks++;
      if (dones !== 1 || lat !== 10) begin
        errors++;
        bad++;
        $display("FAIL b2b_done_%0d: got dones=%0d lat=%0d expected 1 at 10", i, dones, lat);
      end
      checks++;
      if ({got_q, got_r} !== {exp_q, exp_r}) begin
        errors++;
        bad++;
        $display("FAIL b2b_result_%0d: %h/%h got q=%h r=%h expected q=%h r=%h",
                 i, cur_a, cur_b, got_q, got_r, exp_q, exp_r);
      end
      cur_a = nxt_a;
      cur_b = nxt_b;
    end
    $display("back_to_back: %0d runs, %0d bad", RUNS, bad);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_overflow();
    test_div_zero();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
